// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter register for a multicycle MIPS-style datapath. Picks the
// next PC from NUM_SRC packed sources, loads it on unconditional or
// branch-qualified writes, and handles exception entry (EPC capture) and
// ERET return through a two-state RUN/EXC machine.

module pc_sequencer #(
  parameter int                  WIDTH        = 32,
  parameter int                  NUM_SRC      = 4,
  parameter logic [WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0]    EXC_VECTOR   = 32'h8000_0180,
  localparam int                 SEL_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         PCsource,
  input  logic                     PCwrite,
  input  logic                     PCwriteCOND,
  input  logic [1:0]               branch_mode,
  input  logic                     zeroSignal,
  input  logic                     negSignal,
  input  logic                     stall,
  input  logic                     exception,
  input  logic                     eret,
  output logic [WIDTH-1:0]         PC,
  output logic [WIDTH-1:0]         EPC,
  output logic                     exc_active,
  output logic                     misaligned
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } state_t;

  localparam logic [1:0] MODE_BEQ  = 2'b00;
  localparam logic [1:0] MODE_BNE  = 2'b01;
  localparam logic [1:0] MODE_BLEZ = 2'b10;
  localparam logic [1:0] MODE_BGTZ = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;

  logic [31:0]      sel_ext_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             take_branch_s;
  logic             load_s;

  // Zero-extend the select so it can be compared against a loop index.
  assign sel_ext_s = 32'(PCsource);

  // Next-PC source mux; a select beyond the last source yields all zeros.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data_s = (sel_ext_s == i[31:0]) ? src_data[i*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  // Branch condition evaluated from the ALU flags for the selected mode.
  always_comb begin
    take_branch_s = 1'b0;
    case (branch_mode)
      MODE_BEQ:  take_branch_s = zeroSignal;
      MODE_BNE:  take_branch_s = !zeroSignal;
      MODE_BLEZ: take_branch_s = zeroSignal | negSignal;
      MODE_BGTZ: take_branch_s = !zeroSignal & !negSignal;
      default:   take_branch_s = 1'b0;
    endcase
  end

  // A stall blocks ordinary loads but never exception entry or return.
  assign load_s = !stall & (PCwrite | (PCwriteCOND & take_branch_s));

  // Next-state logic: exception entry beats eret, which beats a normal load.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    case (state_q)
      ST_RUN: begin
        if (exception) begin
          epc_d   = pc_q;
          pc_d    = EXC_VECTOR;
          state_d = ST_EXC;
        end else if (load_s) begin
          pc_d = sel_data_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_EXC: begin
        // Further exceptions are masked here, so EPC is never overwritten.
        if (eret) begin
          pc_d    = epc_q;
          state_d = ST_RUN;
        end else if (load_s) begin
          pc_d = sel_data_s;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        pc_d    = pc_q;
        epc_d   = epc_q;
      end
    endcase
  end

  // State, PC and EPC registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  assign PC         = pc_q;
  assign EPC        = epc_q;
  assign exc_active = (state_q == ST_EXC);
  // Alignment is only flagged; the PC itself is never altered.
  assign misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Scoreboard bench: two instances (4 sources and 3 sources) share the
// control inputs. Each cycle a reference model predicts the post-edge state
// of both, pushes it to a queue, and the values are popped and compared
// one time unit after the rising edge.

module tb_pc_sequencer;

  localparam logic [31:0] EXC_VEC = 32'h8000_0180;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exc;
    logic        mis;
  } exp_t;

  logic         Clk;
  logic         Reset;
  logic [31:0]  src [4];
  logic [127:0] src_data4;
  logic [95:0]  src_data3;
  logic [1:0]   PCsource;
  logic         PCwrite;
  logic         PCwriteCOND;
  logic [1:0]   branch_mode;
  logic         zeroSignal;
  logic         negSignal;
  logic         stall;
  logic         exception;
  logic         eret;

  logic [31:0]  pc4, epc4, pc3, epc3;
  logic         exc4, mis4, exc3, mis3;

  // Reference model state, index 0 = 4-source instance, 1 = 3-source.
  logic [31:0]  m_pc  [2];
  logic [31:0]  m_epc [2];
  logic         m_exc [2];

  exp_t         sb_q [$];
  int           total = 0;
  int           bad   = 0;

  assign src_data4 = {src[3], src[2], src[1], src[0]};
  assign src_data3 = {src[2], src[1], src[0]};

  pc_sequencer #(.WIDTH(32), .NUM_SRC(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .src_data(src_data4), .PCsource(PCsource),
    .PCwrite(PCwrite), .PCwriteCOND(PCwriteCOND), .branch_mode(branch_mode),
    .zeroSignal(zeroSignal), .negSignal(negSignal), .stall(stall),
    .exception(exception), .eret(eret),
    .PC(pc4), .EPC(epc4), .exc_active(exc4), .misaligned(mis4)
  );

  pc_sequencer #(.WIDTH(32), .NUM_SRC(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .src_data(src_data3), .PCsource(PCsource),
    .PCwrite(PCwrite), .PCwriteCOND(PCwriteCOND), .branch_mode(branch_mode),
    .zeroSignal(zeroSignal), .negSignal(negSignal), .stall(stall),
    .exception(exception), .eret(eret),
    .PC(pc3), .EPC(epc3), .exc_active(exc3), .misaligned(mis3)
  );

  // Free-running clock, period 10.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d]  = 32'h0000_0000;
      m_epc[d] = 32'h0000_0000;
      m_exc[d] = 1'b0;
    end
  endtask

  // Advance the reference model by one edge for instance d.
  task automatic model_edge(input int d);
    logic [31:0] sel;
    logic        tb_s;
    logic        ld;
    int          nsrc;
    nsrc = (d == 0) ? 4 : 3;
    sel  = (int'(PCsource) < nsrc) ? src[PCsource] : 32'h0000_0000;
    case (branch_mode)
      2'b00:   tb_s = zeroSignal;
      2'b01:   tb_s = !zeroSignal;
      2'b10:   tb_s = zeroSignal || negSignal;
      default: tb_s = !zeroSignal && !negSignal;
    endcase
    ld = !stall && (PCwrite || (PCwriteCOND && tb_s));
    if (!m_exc[d] && exception) begin
      m_epc[d] = m_pc[d];
      m_pc[d]  = EXC_VEC;
      m_exc[d] = 1'b1;
    end else if (m_exc[d] && eret) begin
      m_pc[d]  = m_epc[d];
      m_exc[d] = 1'b0;
    end else if (ld) begin
      m_pc[d] = sel;
    end
  endtask

  // Predict, clock one edge, then pop and compare both instances.
  task automatic step(input string tag);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      model_edge(d);
      e.pc  = m_pc[d];
      e.epc = m_epc[d];
      e.exc = m_exc[d];
      e.mis = |m_pc[d][1:0];
      sb_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check_value({tag, ".pc4"},  pc4,  e.pc);
    check_value({tag, ".epc4"}, epc4, e.epc);
    check_value({tag, ".exc4"}, {31'd0, exc4}, {31'd0, e.exc});
    check_value({tag, ".mis4"}, {31'd0, mis4}, {31'd0, e.mis});
    e = sb_q.pop_front();
    check_value({tag, ".pc3"},  pc3,  e.pc);
    check_value({tag, ".epc3"}, epc3, e.epc);
    check_value({tag, ".exc3"}, {31'd0, exc3}, {31'd0, e.exc});
    check_value({tag, ".mis3"}, {31'd0, mis3}, {31'd0, e.mis});
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    PCwrite = 1'b0; PCwriteCOND = 1'b0; stall = 1'b0;
    exception = 1'b0; eret = 1'b0; zeroSignal = 1'b0; negSignal = 1'b0;
    branch_mode = 2'b00; PCsource = 2'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, ".pc4"},  pc4,  32'h0000_0000);
    check_value({tag, ".epc4"}, epc4, 32'h0000_0000);
    check_value({tag, ".exc4"}, {31'd0, exc4}, 32'd0);
    check_value({tag, ".pc3"},  pc3,  32'h0000_0000);
    check_value({tag, ".exc3"}, {31'd0, exc3}, 32'd0);
  endtask

  // Directed scenarios followed by a random phase.
  initial begin
    Reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) src[i] = 32'h0000_0000;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Unconditional load, then the same with stall.
    PCsource = 2'd1; src[1] = 32'h0000_1000; PCwrite = 1'b1;
    step("load");
    src[1] = 32'h0000_2000; stall = 1'b1;
    step("stall");
    idle_inputs();

    // Branch-qualified loads through every mode.
    PCsource = 2'd2; PCwriteCOND = 1'b1;
    src[2] = 32'h0000_0200; branch_mode = 2'b00; zeroSignal = 1'b1; step("beq_t");
    src[2] = 32'h0000_0300; branch_mode = 2'b01; zeroSignal = 1'b1; step("bne_nt");
    src[2] = 32'h0000_0304; branch_mode = 2'b10; zeroSignal = 1'b0; negSignal = 1'b1; step("blez_t");
    src[2] = 32'h0000_0308; branch_mode = 2'b11; zeroSignal = 1'b0; negSignal = 1'b0; step("bgtz_t");
    src[2] = 32'h0000_030c; branch_mode = 2'b11; negSignal = 1'b1; step("bgtz_nt");
    src[2] = 32'h0000_0310; branch_mode = 2'b00; zeroSignal = 1'b1; stall = 1'b1; step("beq_stall");
    idle_inputs();

    // Exception entry, masking, handler load, eret and eret in RUN.
    PCsource = 2'd0; src[0] = 32'h0000_0400; PCwrite = 1'b1; step("pre_exc");
    src[0] = 32'h0000_0999; exception = 1'b1; step("exc_entry");
    PCwrite = 1'b0; step("exc_masked");
    exception = 1'b0; src[0] = 32'h8000_0200; PCwrite = 1'b1; step("handler_ld");
    stall = 1'b1; eret = 1'b1; step("eret");
    PCwrite = 1'b0; stall = 1'b0; step("eret_in_run");
    idle_inputs();

    // Out-of-range select on the 3-source instance, then misaligned value.
    PCsource = 2'd3; src[3] = 32'h0000_0555; PCwrite = 1'b1; step("sel_oob");
    PCsource = 2'd1; src[1] = 32'h0000_0102; step("misalign");
    idle_inputs();

    // Random phase.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) src[i] = $urandom();
      PCsource    = 2'($urandom_range(0, 3));
      PCwrite     = ($urandom_range(0, 3) == 0);
      PCwriteCOND = ($urandom_range(0, 1) == 0);
      branch_mode = 2'($urandom_range(0, 3));
      zeroSignal  = 1'($urandom_range(0, 1));
      negSignal   = 1'($urandom_range(0, 1));
      stall       = ($urandom_range(0, 3) == 0);
      exception   = ($urandom_range(0, 11) == 0);
      eret        = ($urandom_range(0, 5) == 0);
      step("rand");
    end
    idle_inputs();

    // Drive PC to 0x40 then assert reset asynchronously mid-cycle.
    PCsource = 2'd0; src[0] = 32'h0000_0040; PCwrite = 1'b1; step("pre_rst");
    #3;
    Reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge Clk);
    #1;
    check_reset_state("rst_held");
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    idle_inputs();
    step("post_rst");

    check_value("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
